// File: rtl/hangy_pkg.sv
// Shared definitions for the hangman player-side guess driver.
//   - state_e   : driver state machine encoding
//   - LETTER_W / IN_W / OUT_W : letter code, chip_input and chip_output widths
//   - START_CODE: chip_input pattern that starts a new game in the core
//   - LOST_BIT / WON_BIT : flag positions within chip_output
package hangy_pkg;

  localparam int LETTER_W = 5;
  localparam int IN_W     = 6;
  localparam int OUT_W    = 7;

  localparam logic [IN_W-1:0] START_CODE = 6'b111111;

  localparam int LOST_BIT = 6;
  localparam int WON_BIT  = 5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_SETTLE,
    S_READY,
    S_CHECK,
    S_SEND,
    S_WAIT,
    S_REPORT,
    S_OVER
  } state_e;

endpackage

// File: rtl/hangy_letter_tracker.sv
// Used-letter bookkeeping for one game.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : forget every letter (new game)
//   set        : mark 'letter' as used (ignored for out-of-range codes)
//   letter     : letter code being queried / marked
//   reject     : letter is out of range or already used this game
module hangy_letter_tracker
  import hangy_pkg::*;
#(
  parameter int NUM_LETTERS = 26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                set,
  input  logic [LETTER_W-1:0] letter,
  output logic                reject
);

  localparam int SPAN = 1 << LETTER_W;
  localparam logic [LETTER_W:0] NUM_L = NUM_LETTERS[LETTER_W:0];

  logic [NUM_LETTERS-1:0] used_q, used_d;
  logic [SPAN-1:0]        one_hot;
  logic [SPAN-1:0]        used_ext;
  logic                   in_range;

  // Working in the full code space lets out-of-range codes fall off the top
  // instead of needing a guarded index into the 26-bit map.
  assign one_hot  = SPAN'(1) << letter;
  assign used_ext = SPAN'(used_q);
  assign in_range = {1'b0, letter} < NUM_L;
  assign reject   = !in_range || used_ext[letter];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    used_d = used_q;
    if (clear) begin
      used_d = '0;
    end else if (set) begin
      used_d = used_q | one_hot[NUM_LETTERS-1:0];
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) used_q <= '0;
    else       used_q <= used_d;
  end

endmodule

// File: rtl/hangy_guess_driver.sv
// Player-side front end for the hangman core.
//   clk, reset     : system clock, synchronous active-high reset (shared with core)
//   new_game       : level request to start/restart a game
//   guess_valid/guess_letter/guess_ready : guess request handshake
//   chip_input     : to core, bit5 = strobe, bits4:0 = letter
//   chip_output    : from core, bit6 = lost, bit5 = won, bits4:0 = revealed mask
//   result_valid   : one-cycle pulse per accepted guess
//   result_hit/result_mask/result_err : outcome of that guess (held until next report)
//   game_won/game_lost : sticky until next start
//   miss_count     : misses this game, saturating at MAX_MISSES
module hangy_guess_driver
  import hangy_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int NUM_LETTERS   = 26,
  parameter int MAX_MISSES    = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_game,
  input  logic                guess_valid,
  input  logic [LETTER_W-1:0] guess_letter,
  output logic                guess_ready,
  output logic [IN_W-1:0]     chip_input,
  input  logic [OUT_W-1:0]    chip_output,
  output logic                result_valid,
  output logic                result_hit,
  output logic [LETTER_W-1:0] result_mask,
  output logic                result_err,
  output logic                game_won,
  output logic                game_lost,
  output logic [2:0]          miss_count
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       MISS_MAX = 3'(MAX_MISSES);

  state_e              state_q, state_d;
  logic [LETTER_W-1:0] letter_q, letter_d;
  logic [LETTER_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_W-1:0]     chip_input_q, chip_input_d;
  logic                guess_ready_q, guess_ready_d;
  logic                result_valid_q, result_valid_d;
  logic                result_hit_q, result_hit_d;
  logic [LETTER_W-1:0] result_mask_q, result_mask_d;
  logic                result_err_q, result_err_d;
  logic                game_won_q, game_won_d;
  logic                game_lost_q, game_lost_d;
  logic [2:0]          miss_count_q, miss_count_d;

  logic                trk_clear, trk_set, trk_reject;
  logic [LETTER_W-1:0] new_bits;

  hangy_letter_tracker #(.NUM_LETTERS(NUM_LETTERS)) u_tracker (
    .clk    (clk),
    .reset  (reset),
    .clear  (trk_clear),
    .set    (trk_set),
    .letter (letter_q),
    .reject (trk_reject)
  );

  // Positions the core revealed since the guess was accepted.
  assign new_bits = chip_output[LETTER_W-1:0] & ~snap_q;

  // Outputs are all registered on entry to the state that owns them, so a
  // strobe or result is visible exactly during its START/SEND/REPORT cycle.
  always_comb begin
    state_d        = state_q;
    letter_d       = letter_q;
    snap_d         = snap_q;
    cnt_d          = cnt_q;
    chip_input_d   = '0;
    guess_ready_d  = 1'b0;
    result_valid_d = 1'b0;
    result_hit_d   = result_hit_q;
    result_mask_d  = result_mask_q;
    result_err_d   = result_err_q;
    game_won_d     = game_won_q;
    game_lost_d    = game_lost_q;
    miss_count_d   = miss_count_q;
    trk_clear      = 1'b0;
    trk_set        = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (new_game) begin
          state_d      = S_START;
          chip_input_d = START_CODE;
        end
      end
      S_START: begin
        trk_clear    = 1'b1;
        game_won_d   = 1'b0;
        game_lost_d  = 1'b0;
        miss_count_d = '0;
        cnt_d        = '0;
        state_d      = S_SETTLE;
      end
      S_SETTLE, S_WAIT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (state_q == S_SETTLE) begin
          state_d       = S_READY;
          guess_ready_d = 1'b1;
        end else begin
          state_d        = S_REPORT;
          result_valid_d = 1'b1;
          result_err_d   = 1'b0;
          result_mask_d  = new_bits;
          result_hit_d   = |new_bits;
          game_won_d     = chip_output[WON_BIT];
          game_lost_d    = chip_output[LOST_BIT];
          if (!(|new_bits) && miss_count_q != MISS_MAX) begin
            miss_count_d = miss_count_q + 3'd1;
          end
        end
      end
      S_READY: begin
        guess_ready_d = 1'b1;
        // A restart request wins over a guess offered in the same cycle.
        if (new_game) begin
          state_d       = S_START;
          chip_input_d  = START_CODE;
          guess_ready_d = 1'b0;
        end else if (guess_valid && guess_ready_q) begin
          letter_d      = guess_letter;
          snap_d        = chip_output[LETTER_W-1:0];
          state_d       = S_CHECK;
          guess_ready_d = 1'b0;
        end
      end
      S_CHECK: begin
        if (trk_reject) begin
          state_d        = S_REPORT;
          result_valid_d = 1'b1;
          result_err_d   = 1'b1;
          result_hit_d   = 1'b0;
          result_mask_d  = '0;
        end else begin
          trk_set      = 1'b1;
          chip_input_d = {1'b1, letter_q};
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_REPORT: begin
        if (game_won_q || game_lost_q) begin
          state_d = S_OVER;
        end else begin
          state_d       = S_READY;
          guess_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      letter_q       <= '0;
      snap_q         <= '0;
      cnt_q          <= '0;
      chip_input_q   <= '0;
      guess_ready_q  <= 1'b0;
      result_valid_q <= 1'b0;
      result_hit_q   <= 1'b0;
      result_mask_q  <= '0;
      result_err_q   <= 1'b0;
      game_won_q     <= 1'b0;
      game_lost_q    <= 1'b0;
      miss_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      letter_q       <= letter_d;
      snap_q         <= snap_d;
      cnt_q          <= cnt_d;
      chip_input_q   <= chip_input_d;
      guess_ready_q  <= guess_ready_d;
      result_valid_q <= result_valid_d;
      result_hit_q   <= result_hit_d;
      result_mask_q  <= result_mask_d;
      result_err_q   <= result_err_d;
      game_won_q     <= game_won_d;
      game_lost_q    <= game_lost_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign guess_ready  = guess_ready_q;
  assign chip_input   = chip_input_q;
  assign result_valid = result_valid_q;
  assign result_hit   = result_hit_q;
  assign result_mask  = result_mask_q;
  assign result_err   = result_err_q;
  assign game_won     = game_won_q;
  assign game_lost    = game_lost_q;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_hangy_guess_driver.sv
// Self-checking bench for hangy_guess_driver: a behavioural hangman core
// answers the strobes with a random delay, and a word-level model predicts
// every report (mask, hit, error, misses, win/lose) and its timing.
module tb_hangy_guess_driver;

  localparam int SETTLE = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       guess_valid;
  logic [4:0] guess_letter;
  logic       guess_ready;
  logic [5:0] chip_input;
  logic [6:0] chip_output;
  logic       result_valid;
  logic       result_hit;
  logic [4:0] result_mask;
  logic       result_err;
  logic       game_won;
  logic       game_lost;
  logic [2:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Word in play: word_mem[0] is the first letter and maps to mask bit 4.
  logic [4:0] word_mem [0:4];

  // Reference model state
  logic [31:0] exp_used;
  logic [4:0]  exp_rev;
  int          exp_miss;
  logic        exp_won, exp_lost, exp_over;

  // Behavioural core state
  logic [4:0] core_rev;
  int         core_miss;
  int         pend;
  logic [5:0] pend_code;

  hangy_guess_driver dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (new_game),
    .guess_valid  (guess_valid),
    .guess_letter (guess_letter),
    .guess_ready  (guess_ready),
    .chip_input   (chip_input),
    .chip_output  (chip_output),
    .result_valid (result_valid),
    .result_hit   (result_hit),
    .result_mask  (result_mask),
    .result_err   (result_err),
    .game_won     (game_won),
    .game_lost    (game_lost),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] match(input logic [4:0] l);
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < 5; i++) begin
      if (word_mem[i] == l) m[4-i] = 1'b1;
    end
    return m;
  endfunction

  // Core answers a strobe 1..7 cycles later, within the driver's settle window.
  always @(posedge clk) begin
    if (reset) begin
      chip_output <= '0;
      core_rev    <= '0;
      core_miss   <= 0;
      pend        <= 0;
      pend_code   <= '0;
    end else if (chip_input[5]) begin
      pend      <= int'($urandom_range(1, 7));
      pend_code <= chip_input;
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        if (pend_code == 6'b111111) begin
          core_rev    <= '0;
          core_miss   <= 0;
          chip_output <= '0;
        end else begin
          core_rev    <= core_rev | match(pend_code[4:0]);
          core_miss   <= core_miss + ((match(pend_code[4:0]) == 0) ? 1 : 0);
          chip_output <= {(core_miss + ((match(pend_code[4:0]) == 0) ? 1 : 0)) >= 7,
                          (core_rev | match(pend_code[4:0])) == 5'b11111,
                          core_rev | match(pend_code[4:0])};
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string where);
    check({where, "_guess_ready"},  32'(guess_ready),  0);
    check({where, "_chip_input"},   32'(chip_input),   0);
    check({where, "_result_valid"}, 32'(result_valid), 0);
    check({where, "_result_hit"},   32'(result_hit),   0);
    check({where, "_result_mask"},  32'(result_mask),  0);
    check({where, "_result_err"},   32'(result_err),   0);
    check({where, "_game_won"},     32'(game_won),     0);
    check({where, "_game_lost"},    32'(game_lost),    0);
    check({where, "_miss_count"},   32'(miss_count),   0);
  endtask

  task automatic set_word(input logic [4:0] a, b, c, d, e);
    word_mem[0] = a; word_mem[1] = b; word_mem[2] = c; word_mem[3] = d; word_mem[4] = e;
  endtask

  // Called at a negedge with the driver in IDLE, READY or OVER.
  task automatic start_game(input logic with_guess);
    int k, extra, rv;
    new_game = 1'b1;
    if (with_guess) begin
      guess_valid  = 1'b1;
      guess_letter = 5'd4;
    end
    @(posedge clk);
    @(negedge clk);
    new_game    = 1'b0;
    guess_valid = 1'b0;
    check("start_strobe", 32'(chip_input), 32'h3f);
    exp_used = '0; exp_rev = '0; exp_miss = 0;
    exp_won = 1'b0; exp_lost = 1'b0; exp_over = 1'b0;
    k = 1; extra = 0; rv = 0;
    while (!guess_ready && k < 40) begin
      @(negedge clk);
      k++;
      if (chip_input != 0) extra++;
      if (result_valid) rv++;
    end
    check("ready_latency", k, SETTLE + 2);
    check("start_single_strobe", extra, 0);
    check("start_no_result", rv, 0);
    check("start_miss_count", 32'(miss_count), 0);
    check("start_won", 32'(game_won), 0);
    check("start_lost", 32'(game_lost), 0);
  endtask

  task automatic do_guess(input logic [4:0] l);
    int k, strobes, strobe_at;
    logic err;
    logic [4:0] m;
    logic [5:0] sc;
    k = 0;
    while (!guess_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_guess", 32'(guess_ready), 1);
    err = (l >= 5'd26) || exp_used[l];
    m   = err ? 5'd0 : (match(l) & ~exp_rev);
    guess_valid  = 1'b1;
    guess_letter = l;
    @(posedge clk);
    @(negedge clk);
    guess_valid  = 1'b0;
    guess_letter = 5'($urandom);
    k = 1; strobes = 0; strobe_at = 0; sc = '0;
    while (k < 40) begin
      if (chip_input != 0) begin
        strobes++;
        strobe_at = k;
        sc = chip_input;
      end
      if (result_valid) break;
      @(negedge clk);
      k++;
    end
    check("result_latency", k, err ? 2 : SETTLE + 3);
    check("strobe_count", strobes, err ? 0 : 1);
    if (!err) begin
      check("strobe_cycle", strobe_at, 2);
      check("strobe_code", 32'(sc), 32'({1'b1, l}));
      exp_used[l] = 1'b1;
      exp_rev     = exp_rev | m;
      if (m == 0 && exp_miss < 7) exp_miss++;
      exp_won  = (exp_rev == 5'b11111);
      exp_lost = (exp_miss >= 7);
      exp_over = exp_won || exp_lost;
    end
    check("result_err",  32'(result_err),  32'(err));
    check("result_hit",  32'(result_hit),  32'(m != 0));
    check("result_mask", 32'(result_mask), 32'(m));
    check("miss_count",  32'(miss_count),  exp_miss);
    check("game_won",    32'(game_won),    32'(exp_won));
    check("game_lost",   32'(game_lost),   32'(exp_lost));
    check("ready_in_report", 32'(guess_ready), 0);
    @(negedge clk);
    check("result_pulse", 32'(result_valid), 0);
    check("result_mask_hold", 32'(result_mask), 32'(m));
    check("ready_after_report", 32'(guess_ready), 32'(!exp_over));
  endtask

  initial begin
    int k, bad;
    logic [4:0] pick;
    reset = 1'b1; new_game = 1'b0; guess_valid = 1'b0; guess_letter = '0;
    exp_used = '0; exp_rev = '0; exp_miss = 0;
    exp_won = 1'b0; exp_lost = 1'b0; exp_over = 1'b0;
    set_word(5'd13, 5'd14, 5'd19, 5'd17, 5'd4);    // notre
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(guess_ready), 0);
    check("idle_chip_input", 32'(chip_input), 0);

    // Word notre: hit, duplicate, out-of-range, then win.
    start_game(1'b0);
    do_guess(5'd13);
    do_guess(5'd13);
    do_guess(5'd26);
    do_guess(5'd14);
    do_guess(5'd19);
    do_guess(5'd17);
    do_guess(5'd4);
    repeat (5) @(negedge clk);
    check("over_ready", 32'(guess_ready), 0);
    check("over_won_held", 32'(game_won), 1);

    // Seven misses lose the game.
    start_game(1'b0);
    do_guess(5'd0); do_guess(5'd1); do_guess(5'd2); do_guess(5'd3);
    do_guess(5'd6); do_guess(5'd7); do_guess(5'd8);
    check("lost_final", 32'(game_lost), 1);

    // Reset while waiting on the core aborts everything.
    start_game(1'b0);
    guess_valid  = 1'b1;
    guess_letter = 5'd14;
    @(posedge clk);
    @(negedge clk);
    guess_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("abort");
    reset = 1'b0;
    bad = 0;
    k = 0;
    while (k < 15) begin
      @(negedge clk);
      if (chip_input != 0 || guess_ready || result_valid) bad++;
      k++;
    end
    check("abort_stays_idle", bad, 0);

    // Restart wins over a guess offered in the same READY cycle.
    start_game(1'b0);
    start_game(1'b1);
    do_guess(5'd4);

    // Random games against the reference model.
    for (int g = 0; g < 4; g++) begin
      set_word(5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)),
               5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)),
               5'($urandom_range(0, 25)));
      start_game(1'b0);
      for (int n = 0; n < 16 && !exp_over; n++) begin
        if ($urandom_range(0, 1) == 0) pick = word_mem[$urandom_range(0, 4)];
        else                           pick = 5'($urandom_range(0, 31));
        do_guess(pick);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
